bus_arbiter_split: RTL and testbench
====================================

Name: bus_arbiter_split

Overview:
- Central arbiter and bus sequencer inside the bus interconnect.
- Shares the single system bus between two masters (M1, M2) and SLAVE_COUNT slaves.
- Grants the bus, collects the bit-serial slave address from the granted master, and drives the master/slave mux selects for the datapath.
- Supports split transactions: a slave may release the bus mid-transaction and later resume with its original master.

Parameters:
SLAVE_LEN, 2, width of slave id; serial address length in bits.
SLAVE_COUNT, 3, number of valid slaves; ids 0..SLAVE_COUNT-1.
TIMEOUT, 255, max cycles in ACTIVE before forced release.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  one clock; reset is asynchronous and active-low (reset=0 resets all state).
m1_request  in  1  M1 bus request, level.
m2_request  in  1  M2 bus request, level.
m1_slave_sel  in  1  M1 serial slave id, MSB first.
m2_slave_sel  in  1  M2 serial slave id, MSB first.
trans_done  in  1  granted transaction complete, 1-cycle pulse.
split_en  in  1  selected slave requests split, 1-cycle pulse.
split_resume  in  SLAVE_COUNT  per-slave pulse: split slave ready to resume.
m1_grant  out  1  M1 owns bus.
m2_grant  out  1  M2 owns bus.
arbiter_busy  out  1  arbiter in ADDR or ACTIVE.
bus_busy  out  1  data phase active (ACTIVE state).
master_sel  out  1  0=M1, 1=M2; valid while a grant is high.
slave_sel  out  SLAVE_LEN  decoded slave id for slave-side mux.
slave_sel_valid  out  1  slave_sel valid (ACTIVE only).
arb_err  out  1  1-cycle pulse: invalid id, split-slave conflict, or timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; split pending cleared; resume flags cleared.
- All outputs are registered. A request sampled at edge t produces a grant during cycle t+1.
- IDLE:
  - Priority 1: resume flag set for the pending split slave -> grant the split master directly into ACTIVE with its stored slave_sel; no address phase.
  - Priority 2: m1_request -> grant M1.
  - Priority 3: m2_request -> grant M2.
  - A master with a split pending is ignored in arbitration until it is resumed.
  - On a new grant: go to ADDR, bit counter=0.
- ADDR:
  - grant=1, arbiter_busy=1, bus_busy=0, slave_sel_valid=0.
  - Shift in mX_slave_sel for exactly SLAVE_LEN cycles, MSB first.
  - After the last bit, if id>=SLAVE_COUNT, or id equals the slave currently holding a pending split: drop grant, arb_err pulse, go to IDLE.
  - Otherwise go to ACTIVE: bus_busy=1, slave_sel_valid=1, timeout counter=0.
- ACTIVE:
  - Timeout counter increments each cycle.
  - trans_done -> drop grant, bus_busy and arbiter_busy next cycle, go to IDLE.
  - Counter reaches TIMEOUT -> forced release to IDLE with arb_err pulse.
  - split_en with no split pending -> store master and slave id, release bus, go to IDLE.
  - split_en while a split is already pending -> ignored; transaction continues.
- Resume handling:
  - split_resume[id] for the pending split slave sets a sticky resume flag, even if the bus is busy.
  - Pulses from non-split slaves are ignored.
  - The resumed transaction clears the split pending state when it finishes (trans_done or timeout).
- Abort: if the granted master deasserts its request in ADDR or ACTIVE, go to IDLE next cycle with no error.
- Simultaneous events:
  - trans_done beats split_en.
  - trans_done beats timeout.
  - M1 beats M2 only for new grants; a resume beats both.
- After every release, at least 1 IDLE cycle with no grant (bus turnaround).
- m1_grant and m2_grant are never both 1.
- Async reset mid-transaction: all grants drop immediately, pending split is discarded.

Test Plan:
- Single write: m1_request=1, serial bits 0,1 -> m1_grant at t+1; ADDR 2 cycles; then bus_busy=1, slave_sel=1, master_sel=0; trans_done -> grant=0 next cycle.
- Contention: m1_request and m2_request rise in the same cycle -> M1 granted first; after M1 trans_done, 1 idle cycle, then m2_grant=1.
- Split: M1 to slave 2, split_en -> release. M2 to slave 0 runs ACTIVE. split_resume[2] during M2 -> after M2 done, M1 resumed straight into ACTIVE with slave_sel=2.
- Conflict and invalid id:
  - During the split above, M2 addresses slave 2 -> arb_err pulse, no ACTIVE.
  - Serial id 3 -> arb_err pulse, no ACTIVE.
- Timeout: TIMEOUT=8 with no trans_done -> release after 8 ACTIVE cycles, arb_err=1 for 1 cycle.
- Reset: reset=0 while ACTIVE -> all outputs 0 asynchronously; after release, the arbiter accepts a new request normally.

Source files
------------

// File: rtl/bus_arbiter_split_if.sv
// bus_arbiter_split_if: request/grant, serial address and mux-select signals between masters and the split arbiter
interface bus_arbiter_split_if #(
    parameter int SLAVE_LEN   = 2,
    parameter int SLAVE_COUNT = 3
);
    logic                   m1_request;
    logic                   m2_request;
    logic                   m1_slave_sel;
    logic                   m2_slave_sel;
    logic                   trans_done;
    logic                   split_en;
    logic [SLAVE_COUNT-1:0] split_resume;
    logic                   m1_grant;
    logic                   m2_grant;
    logic                   arbiter_busy;
    logic                   bus_busy;
    logic                   master_sel;
    logic [SLAVE_LEN-1:0]   slave_sel;
    logic                   slave_sel_valid;
    logic                   arb_err;

    modport slave (
        input  m1_request, m2_request, m1_slave_sel, m2_slave_sel,
        input  trans_done, split_en, split_resume,
        output m1_grant, m2_grant, arbiter_busy, bus_busy,
        output master_sel, slave_sel, slave_sel_valid, arb_err
    );

    modport master (
        output m1_request, m2_request, m1_slave_sel, m2_slave_sel,
        output trans_done, split_en, split_resume,
        input  m1_grant, m2_grant, arbiter_busy, bus_busy,
        input  master_sel, slave_sel, slave_sel_valid, arb_err
    );
endinterface

// File: rtl/bus_arbiter_split.sv
// bus_arbiter_split: two-master bus arbiter with serial slave addressing, timeout and split/resume support
module bus_arbiter_split #(
    parameter int SLAVE_LEN   = 2,
    parameter int SLAVE_COUNT = 3,
    parameter int TIMEOUT     = 255
) (
    input logic                clk,
    input logic                rst_n,
    bus_arbiter_split_if.slave bus
);
    localparam int BW = $clog2(SLAVE_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, ACTIVE} state_t;

    state_t               r_state;
    logic                 r_m1_grant;
    logic                 r_m2_grant;
    logic                 r_arbiter_busy;
    logic                 r_bus_busy;
    logic                 r_master_sel;
    logic [SLAVE_LEN-1:0] r_slave_sel;
    logic                 r_slave_sel_valid;
    logic                 r_arb_err;
    logic [SLAVE_LEN-1:0] r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic [TW-1:0]        r_to_cnt;
    logic                 r_pending;
    logic                 r_resume;
    logic                 r_split_master;
    logic [SLAVE_LEN-1:0] r_split_slave;

    logic                 w_m1_req;
    logic                 w_m2_req;
    logic                 w_req_cur;
    logic                 w_bit;
    logic [SLAVE_LEN-1:0] w_id;
    logic                 w_last;
    logic                 w_bad_id;
    logic                 w_timeout;
    logic                 w_resumed;
    logic                 w_split;
    logic                 w_release;
    logic                 w_err;

    // A master parked on a split is invisible to arbitration until its slave resumes it
    assign w_m1_req  = bus.m1_request && !(r_pending && !r_split_master);
    assign w_m2_req  = bus.m2_request && !(r_pending && r_split_master);
    assign w_req_cur = r_master_sel ? bus.m2_request : bus.m1_request;
    assign w_bit     = r_master_sel ? bus.m2_slave_sel : bus.m1_slave_sel;
    assign w_id      = SLAVE_LEN'({r_shift, w_bit});
    assign w_last    = r_bit_cnt == BW'(SLAVE_LEN - 1);
    assign w_bad_id  = ({1'b0, w_id} >= (SLAVE_LEN + 1)'(SLAVE_COUNT)) || (r_pending && w_id == r_split_slave);
    assign w_timeout = r_to_cnt == TW'(TIMEOUT - 1);
    assign w_resumed = r_pending && (r_master_sel == r_split_master);
    // Completion outranks abort, abort outranks timeout, timeout outranks a split request
    assign w_split   = (r_state == ACTIVE) && !bus.trans_done && w_req_cur && !w_timeout && bus.split_en && !r_pending;
    assign w_release = (r_state == ADDR)   ? (!w_req_cur || (w_last && w_bad_id)) :
                       (r_state == ACTIVE) ? (bus.trans_done || !w_req_cur || w_timeout || w_split) : 1'b0;
    assign w_err     = (r_state == ADDR)   ? (w_req_cur && w_last && w_bad_id) :
                       (r_state == ACTIVE) ? (!bus.trans_done && w_req_cur && w_timeout) : 1'b0;

    assign bus.m1_grant        = r_m1_grant;
    assign bus.m2_grant        = r_m2_grant;
    assign bus.arbiter_busy    = r_arbiter_busy;
    assign bus.bus_busy        = r_bus_busy;
    assign bus.master_sel      = r_master_sel;
    assign bus.slave_sel       = r_slave_sel;
    assign bus.slave_sel_valid = r_slave_sel_valid;
    assign bus.arb_err         = r_arb_err;

    // Arbitration FSM with registered outputs, split bookkeeping and sticky resume capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_m1_grant        <= 1'b0;
            r_m2_grant        <= 1'b0;
            r_arbiter_busy    <= 1'b0;
            r_bus_busy        <= 1'b0;
            r_master_sel      <= 1'b0;
            r_slave_sel       <= '0;
            r_slave_sel_valid <= 1'b0;
            r_arb_err         <= 1'b0;
            r_shift           <= '0;
            r_bit_cnt         <= '0;
            r_to_cnt          <= '0;
            r_pending         <= 1'b0;
            r_resume          <= 1'b0;
            r_split_master    <= 1'b0;
            r_split_slave     <= '0;
        end else begin
            r_arb_err <= w_err;
            if (r_pending && bus.split_resume[r_split_slave]) r_resume <= 1'b1;
            if (w_release) begin
                r_state           <= IDLE;
                r_m1_grant        <= 1'b0;
                r_m2_grant        <= 1'b0;
                r_arbiter_busy    <= 1'b0;
                r_bus_busy        <= 1'b0;
                r_master_sel      <= 1'b0;
                r_slave_sel       <= '0;
                r_slave_sel_valid <= 1'b0;
                if (w_split) begin
                    r_pending      <= 1'b1;
                    r_split_master <= r_master_sel;
                    r_split_slave  <= r_slave_sel;
                end else if (r_state == ACTIVE && w_resumed) begin
                    r_pending <= 1'b0;
                    r_resume  <= 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        if (r_pending && r_resume) begin
                            r_state           <= ACTIVE;
                            r_m1_grant        <= !r_split_master;
                            r_m2_grant        <= r_split_master;
                            r_master_sel      <= r_split_master;
                            r_slave_sel       <= r_split_slave;
                            r_arbiter_busy    <= 1'b1;
                            r_bus_busy        <= 1'b1;
                            r_slave_sel_valid <= 1'b1;
                            r_to_cnt          <= '0;
                            r_resume          <= 1'b0;
                        end else if (w_m1_req || w_m2_req) begin
                            r_state        <= ADDR;
                            r_m1_grant     <= w_m1_req;
                            r_m2_grant     <= !w_m1_req;
                            r_master_sel   <= !w_m1_req;
                            r_arbiter_busy <= 1'b1;
                        end
                    end
                    ADDR: begin
                        r_shift   <= w_id;
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                        if (w_last) begin
                            r_state           <= ACTIVE;
                            r_bus_busy        <= 1'b1;
                            r_slave_sel       <= w_id;
                            r_slave_sel_valid <= 1'b1;
                            r_to_cnt          <= '0;
                        end
                    end
                    ACTIVE:  r_to_cnt <= r_to_cnt + TW'(1);
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter_split.sv
// tb_bus_arbiter_split: directed scenario checks of grant, addressing, split/resume, errors, timeout and reset
module tb_bus_arbiter_split;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] obs;
    logic [8:0] exp;

    bus_arbiter_split_if #(.SLAVE_LEN(2), .SLAVE_COUNT(3)) bus_if ();

    bus_arbiter_split #(.SLAVE_LEN(2), .SLAVE_COUNT(3), .TIMEOUT(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    // {m1_grant, m2_grant, arbiter_busy, bus_busy, master_sel, slave_sel[1:0], slave_sel_valid, arb_err}
    assign obs = {bus_if.m1_grant, bus_if.m2_grant, bus_if.arbiter_busy, bus_if.bus_busy,
                  bus_if.master_sel, bus_if.slave_sel, bus_if.slave_sel_valid, bus_if.arb_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_if.m1_request = 0; bus_if.m2_request = 0; bus_if.m1_slave_sel = 0; bus_if.m2_slave_sel = 0;
        bus_if.trans_done = 0; bus_if.split_en = 0; bus_if.split_resume = '0;
        rst_n = 0;
        tick(); tick();
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, exp); end
        rst_n = 1;
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL idle_after_reset: got %b expected %b", obs, exp); end
    endtask

    task automatic test_single();
        bus_if.m1_request = 1; bus_if.m1_slave_sel = 0;
        tick();
        exp = 9'b1_0_1_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL single_grant: got %b expected %b", obs, exp); end
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL single_addr2: got %b expected %b", obs, exp); end
        bus_if.m1_slave_sel = 1;
        tick();
        exp = 9'b1_0_1_1_0_01_1_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL single_active: got %b expected %b", obs, exp); end
        bus_if.trans_done = 1;
        tick();
        bus_if.trans_done = 0; bus_if.m1_request = 0; bus_if.m1_slave_sel = 0;
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL single_release: got %b expected %b", obs, exp); end
        tick();
    endtask

    task automatic test_contention();
        bus_if.m1_request = 1; bus_if.m2_request = 1; bus_if.m1_slave_sel = 0; bus_if.m2_slave_sel = 0;
        tick();
        exp = 9'b1_0_1_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL cont_m1_first: got %b expected %b", obs, exp); end
        tick(); tick();
        exp = 9'b1_0_1_1_0_00_1_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL cont_m1_active: got %b expected %b", obs, exp); end
        bus_if.trans_done = 1; bus_if.m1_request = 0;
        tick();
        bus_if.trans_done = 0;
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL cont_turnaround: got %b expected %b", obs, exp); end
        tick();
        exp = 9'b0_1_1_0_1_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL cont_m2_grant: got %b expected %b", obs, exp); end
        tick(); tick();
        exp = 9'b0_1_1_1_1_00_1_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL cont_m2_active: got %b expected %b", obs, exp); end
        bus_if.trans_done = 1; bus_if.m2_request = 0;
        tick();
        bus_if.trans_done = 0;
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL cont_m2_release: got %b expected %b", obs, exp); end
        tick();
    endtask

    task automatic test_split();
        bus_if.m1_request = 1; bus_if.m1_slave_sel = 1;
        tick(); tick();
        bus_if.m1_slave_sel = 0;
        tick();
        exp = 9'b1_0_1_1_0_10_1_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL split_m1_active: got %b expected %b", obs, exp); end
        bus_if.split_en = 1;
        tick();
        bus_if.split_en = 0;
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL split_release: got %b expected %b", obs, exp); end
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL split_master_ignored: got %b expected %b", obs, exp); end
        bus_if.m2_request = 1; bus_if.m2_slave_sel = 1;
        tick();
        exp = 9'b0_1_1_0_1_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL conflict_m2_grant: got %b expected %b", obs, exp); end
        tick();
        bus_if.m2_slave_sel = 0;
        tick();
        exp = 9'b0_0_0_0_0_00_0_1; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL conflict_err: got %b expected %b", obs, exp); end
        tick();
        exp = 9'b0_1_1_0_1_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL conflict_err_pulse: got %b expected %b", obs, exp); end
        tick(); tick();
        exp = 9'b0_1_1_1_1_00_1_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL split_m2_active: got %b expected %b", obs, exp); end
        bus_if.split_resume = 3'b100;
        tick();
        bus_if.split_resume = 3'b000; bus_if.split_en = 1;
        tick();
        bus_if.split_en = 0;
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL split_second_ignored: got %b expected %b", obs, exp); end
        bus_if.trans_done = 1; bus_if.m2_request = 0;
        tick();
        bus_if.trans_done = 0;
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL split_m2_release: got %b expected %b", obs, exp); end
        tick();
        exp = 9'b1_0_1_1_0_10_1_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL resume_direct_active: got %b expected %b", obs, exp); end
        bus_if.trans_done = 1;
        tick();
        bus_if.trans_done = 0; bus_if.m1_request = 0;
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL resume_release: got %b expected %b", obs, exp); end
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL resume_cleared: got %b expected %b", obs, exp); end
    endtask

    task automatic test_invalid_id();
        bus_if.m1_request = 1; bus_if.m1_slave_sel = 1;
        tick(); tick(); tick();
        bus_if.m1_request = 0; bus_if.m1_slave_sel = 0;
        exp = 9'b0_0_0_0_0_00_0_1; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL invalid_id_err: got %b expected %b", obs, exp); end
        tick();
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL invalid_id_pulse: got %b expected %b", obs, exp); end
    endtask

    task automatic test_timeout();
        bus_if.m1_request = 1; bus_if.m1_slave_sel = 0;
        tick(); tick(); tick();
        exp = 9'b1_0_1_1_0_00_1_0;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL timeout_active_%0d: got %b expected %b", i, obs, exp); end
            tick();
        end
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL timeout_active_7: got %b expected %b", obs, exp); end
        tick();
        bus_if.m1_request = 0;
        exp = 9'b0_0_0_0_0_00_0_1; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL timeout_err: got %b expected %b", obs, exp); end
        tick();
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected %b", obs, exp); end
    endtask

    task automatic test_reset_mid();
        bus_if.m1_request = 1; bus_if.m1_slave_sel = 0;
        tick(); tick(); tick();
        exp = 9'b1_0_1_1_0_00_1_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rst_pre_active: got %b expected %b", obs, exp); end
        #2 rst_n = 0;
        #1;
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rst_async_clear: got %b expected %b", obs, exp); end
        #1 rst_n = 1;
        tick();
        exp = 9'b1_0_1_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rst_new_grant: got %b expected %b", obs, exp); end
        bus_if.m1_request = 0;
        tick();
        exp = 9'b0_0_0_0_0_00_0_0; n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL abort_no_err: got %b expected %b", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_split();
        test_invalid_id();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
